// File: rtl/clk_div_monitor.sv
// Period and duty-cycle monitor for a divided clock sampled in the clk_in domain.
// Measures high/low time in clk_in cycles and flags frequency errors and a stuck div_clk.
module clk_div_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic             en,
    input  logic [CNT_W:0]   exp_period,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             freq_err,
    output logic             stuck
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lvl_d_reg;
    logic                   lvl;
    logic                   rise;
    logic                   fall;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
    logic [CNT_W-1:0] low_cnt_reg, low_cnt_next;
    logic [CNT_W:0]   period_reg, period_next;
    logic [CNT_W-1:0] high_time_reg, high_time_next;
    logic             meas_valid_reg, meas_valid_next;
    logic             freq_err_reg, freq_err_next;
    logic             stuck_reg, stuck_next;

    logic [CNT_W:0]   meas_period;
    logic [CNT_W:0]   period_diff;
    logic             meas_err;

    // Synchronizer plus one delay flop; runs regardless of en so edges stay coherent.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            lvl_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], div_clk};
            lvl_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_reg[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_d_reg;
    assign fall = ~lvl & lvl_d_reg;

    assign meas_period = {1'b0, high_cnt_reg} + {1'b0, low_cnt_reg};
    assign period_diff = (meas_period >= exp_period) ? (meas_period - exp_period)
                                                     : (exp_period - meas_period);
    assign meas_err    = period_diff > {1'b0, tol};

    always_comb begin
        state_next      = state_reg;
        high_cnt_next   = high_cnt_reg;
        low_cnt_next    = low_cnt_reg;
        period_next     = period_reg;
        high_time_next  = high_time_reg;
        meas_valid_next = 1'b0;
        freq_err_next   = freq_err_reg;
        stuck_next      = stuck_reg;

        if (!en) begin
            state_next    = ST_IDLE;
            high_cnt_next = '0;
            low_cnt_next  = '0;
            stuck_next    = 1'b0;
        end else begin
            if (rise || fall) begin
                stuck_next = 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (rise) begin
                        high_cnt_next = CNT_ONE;
                        low_cnt_next  = '0;
                        state_next    = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        low_cnt_next = CNT_ONE;
                        state_next   = ST_LOW;
                    end else if (high_cnt_reg == CNT_MAX - 1'b1) begin
                        // Saturation abandons the measurement; outputs keep the last good one.
                        high_cnt_next = CNT_MAX;
                        stuck_next    = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        high_cnt_next = high_cnt_reg + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_next     = meas_period;
                        high_time_next  = high_cnt_reg;
                        freq_err_next   = meas_err;
                        meas_valid_next = 1'b1;
                        high_cnt_next   = CNT_ONE;
                        low_cnt_next    = '0;
                        state_next      = ST_HIGH;
                    end else if (low_cnt_reg == CNT_MAX - 1'b1) begin
                        low_cnt_next = CNT_MAX;
                        stuck_next   = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        low_cnt_next = low_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            high_cnt_reg   <= '0;
            low_cnt_reg    <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            freq_err_reg   <= 1'b0;
            stuck_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            high_cnt_reg   <= high_cnt_next;
            low_cnt_reg    <= low_cnt_next;
            period_reg     <= period_next;
            high_time_reg  <= high_time_next;
            meas_valid_reg <= meas_valid_next;
            freq_err_reg   <= freq_err_next;
            stuck_reg      <= stuck_next;
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = meas_valid_reg;
    assign freq_err   = freq_err_reg;
    assign stuck      = stuck_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_clk_div_monitor;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             div_clk = 1'b0;
    logic             en = 1'b1;
    logic [CNT_W:0]   exp_period = '0;
    logic [CNT_W-1:0] tol = '0;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             freq_err;
    logic             stuck;

    int checks = 0;
    int errors = 0;

    clk_div_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .div_clk    (div_clk),
        .en         (en),
        .exp_period (exp_period),
        .tol        (tol),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .freq_err   (freq_err),
        .stuck      (stuck)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: div_clk samples history, edges as timestamps, measurements as differences.
    int               cyc = 0;
    bit               hist [8];
    int               armed = -1;
    int               fall_t = -1;
    logic [CNT_W:0]   m_period = '0;
    logic [CNT_W-1:0] m_high = '0;
    bit               m_mv = 1'b0;
    bit               m_ferr = 1'b0;
    bit               m_stuck = 1'b0;

    always @(posedge clk_in) begin
        bit lv, lp, r, f;
        int diff, run;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist[i] = 1'b0;
            armed = -1; fall_t = -1;
            m_period = '0; m_high = '0; m_mv = 1'b0; m_ferr = 1'b0; m_stuck = 1'b0;
        end else begin
            cyc++;
            lv = hist[SYNC-1];
            lp = hist[SYNC];
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = div_clk;
            r = lv & !lp;
            f = !lv & lp;
            m_mv = 1'b0;
            if (!en) begin
                armed = -1; fall_t = -1; m_stuck = 1'b0;
            end else if (r) begin
                m_stuck = 1'b0;
                if (armed >= 0 && fall_t >= 0) begin
                    m_high   = CNT_W'(fall_t - armed);
                    m_period = (CNT_W+1)'(cyc - armed);
                    diff = (cyc - armed) - int'(exp_period);
                    if (diff < 0) diff = -diff;
                    m_ferr = diff > int'(tol);
                    m_mv   = 1'b1;
                end
                armed = cyc; fall_t = -1;
            end else if (f) begin
                m_stuck = 1'b0;
                if (armed >= 0) fall_t = cyc;
            end else if (armed >= 0) begin
                run = (fall_t < 0) ? (cyc - armed + 1) : (cyc - fall_t + 1);
                if (run >= MAXC) begin
                    m_stuck = 1'b1; armed = -1; fall_t = -1;
                end
            end
        end
        #2;
        checks++;
        if ({period, high_time, meas_valid, freq_err, stuck} !==
            {m_period, m_high, m_mv, m_ferr, m_stuck}) begin
            errors++;
            $display("FAIL model_compare t=%0t: got period=%0d high_time=%0d meas_valid=%b freq_err=%b stuck=%b, required period=%0d high_time=%0d meas_valid=%b freq_err=%b stuck=%b",
                     $time, period, high_time, meas_valid, freq_err, stuck,
                     m_period, m_high, m_mv, m_ferr, m_stuck);
        end else if (meas_valid) begin
            $display("meas t=%0t period=%0d high_time=%0d freq_err=%b", $time, period, high_time, freq_err);
        end
    end

    // div_clk generator: 0 static, 1 periodic hi/lo, 2 random runs
    int mode = 2;
    bit static_lvl = 1'b0;
    int hi_n = 1, lo_n = 2, ph = 0, run_left = 0;
    bit rlvl = 1'b0;

    task automatic tick();
        @(negedge clk_in);
        case (mode)
            0: div_clk = static_lvl;
            1: begin
                div_clk = (ph < hi_n);
                ph = (ph + 1) % (hi_n + lo_n);
            end
            default: begin
                if (run_left == 0) begin
                    rlvl = !rlvl;
                    run_left = ($urandom_range(0, 59) == 0) ? 300 : int'($urandom_range(1, 8));
                end
                div_clk = rlvl;
                run_left--;
            end
        endcase
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic set_pattern(input int h, input int l);
        mode = 1; hi_n = h; lo_n = l; ph = 0;
    endtask

    task automatic wait_mv(input int maxc, output int k);
        bit found;
        found = 1'b0;
        k = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            tick();
            k++;
            if (meas_valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL meas_valid_timeout: got no pulse in %0d cycles, required one", maxc);
        end
    endtask

    initial begin
        int k, nmv, sk, sc;

        // Reset held while div_clk toggles
        rst_n = 1'b0; en = 1'b1; mode = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset_outputs_zero", int'({period, high_time, meas_valid, freq_err, stuck}), 0);
        end
        tick();
        rst_n = 1'b1; mode = 0; static_lvl = 1'b0; div_clk = 1'b0;
        nmv = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (meas_valid) nmv++;
        end
        chk("no_meas_static_low", nmv, 0);

        // Divide-by-3
        exp_period = 9'd3; tol = 8'd0;
        set_pattern(1, 2);
        wait_mv(20, k);
        chk("div3_period", int'(period), 3);
        chk("div3_high_time", int'(high_time), 1);
        chk("div3_freq_err", int'(freq_err), 0);
        wait_mv(10, k);
        chk("div3_cadence_1", k, 3);
        wait_mv(10, k);
        chk("div3_cadence_2", k, 3);

        // Frequency error, then widened tolerance
        tol = 8'd1;
        set_pattern(3, 2);
        wait_mv(20, k); wait_mv(20, k); wait_mv(20, k);
        chk("ferr_period", int'(period), 5);
        chk("ferr_high_time", int'(high_time), 3);
        chk("ferr_flag", int'(freq_err), 1);
        tol = 8'd2;
        wait_mv(20, k);
        chk("ferr_tol2_period", int'(period), 5);
        chk("ferr_tol2_flag", int'(freq_err), 0);

        // Stuck high
        set_pattern(1, 2);
        wait_mv(20, k); wait_mv(20, k); wait_mv(20, k);
        mode = 0; static_lvl = 1'b1;
        wait_mv(10, k);
        chk("stuck_last_meas_delay", k, 3);
        chk("stuck_last_meas_period", int'(period), 3);
        nmv = 0; sk = -1;
        for (int i = 4; i <= 400 && sk < 0; i++) begin
            tick();
            if (meas_valid) nmv++;
            if (stuck) sk = i;
        end
        chk("stuck_assert_delay", sk, 257);
        chk("no_meas_while_stuck", nmv, 0);
        set_pattern(1, 2);
        sc = -1;
        for (int i = 1; i <= 20 && sc < 0; i++) begin
            tick();
            if (!stuck) sc = i;
        end
        chk("stuck_clear_delay", sc, 5);
        wait_mv(30, k);
        chk("post_stuck_first_meas", k, 5);
        chk("post_stuck_period", int'(period), 3);

        // Enable dropped during LOW
        set_pattern(2, 3);
        wait_mv(20, k); wait_mv(20, k); wait_mv(20, k);
        chk("en_pre_period", int'(period), 5);
        chk("en_pre_high_time", int'(high_time), 2);
        tick(); tick();
        en = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk("en_low_hold", int'({period, high_time}), (5 << CNT_W) | 2);
            chk("en_low_quiet", int'({meas_valid, stuck}), 0);
        end
        en = 1'b1;
        wait_mv(40, k);
        chk("en_reassert_meas_delay", k, 9);
        chk("en_reassert_period", int'(period), 5);

        // Reset pulse during HIGH
        set_pattern(1, 2);
        wait_mv(20, k); wait_mv(20, k); wait_mv(20, k);
        chk("rst_pre_period", int'(period), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_period", int'(period), 0);
        chk("rst_async_others", int'({high_time, meas_valid, freq_err, stuck}), 0);
        tick();
        rst_n = 1'b1;
        wait_mv(30, k);
        chk("rst_remeasure_period", int'(period), 3);
        chk("rst_remeasure_high_time", int'(high_time), 1);

        // Randomized soak against the model
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 49) == 0) begin
                exp_period = 9'($urandom_range(2, 20));
                tol = 8'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 199) == 0) en = !en;
            if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        en = 1'b1;
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
